// File: rtl/arb_rr8.sv
// Round-robin arbiter for eight requesters with a bounded grant tenure.
// The one-hot grant comes from a decoder38 driven by the registered index.

module decoder38 (
    input  logic       a2,
    input  logic       a1,
    input  logic       a0,
    input  logic       en,
    output logic [7:0] y
);
    always_comb begin
        y = '0;
        if (en) begin
            y[{a2, a1, a0}] = 1'b1;
        end
    end
endmodule

module arb_rr8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EN,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic [2:0] ptr
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q;
    logic [2:0] gnt_idx_q;
    logic [2:0] ptr_q;
    logic [7:0] hold_cnt_q;

    logic       win_vld;
    logic [2:0] win_idx;
    logic [2:0] scan_idx;

    // Scan from the farthest offset down so the requester nearest ptr wins.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = ptr_q;
        scan_idx = '0;
        for (int k = 7; k >= 0; k--) begin
            scan_idx = ptr_q + 3'(k);
            if (req[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_idx_q  <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (EN && win_vld) begin
                        state_q    <= BUSY;
                        gnt_idx_q  <= win_idx;
                        hold_cnt_q <= '0;
                    end
                end
                BUSY: begin
                    // Voluntary and forced release both move priority past the holder.
                    if (!req[gnt_idx_q] || (hold_cnt_q == HOLD_LAST)) begin
                        state_q    <= IDLE;
                        ptr_q      <= gnt_idx_q + 3'd1;
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt_vld = (state_q == BUSY);
    assign gnt_idx = gnt_idx_q;
    assign ptr     = ptr_q;

    decoder38 u_dec (
        .a2 (gnt_idx_q[2]),
        .a1 (gnt_idx_q[1]),
        .a0 (gnt_idx_q[0]),
        .en (gnt_vld),
        .y  (gnt)
    );
endmodule
